// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer.
//   ns_sel_e   : next-state select codes carried in the control word
//   cond_sel_e : condition select codes for the branch/wait condition mux
//   MICROSEQ_ADDR_W : default micro-PC / microstore index width
package microseq_pkg;

  localparam int MICROSEQ_ADDR_W = 6;

  typedef enum logic [2:0] {
    NS_INC     = 3'b000,
    NS_JUMP    = 3'b001,
    NS_DECODE  = 3'b010,
    NS_CBRANCH = 3'b011,
    NS_WAIT    = 3'b100,
    NS_CALL    = 3'b101,
    NS_RETURN  = 3'b110,
    NS_FETCH   = 3'b111
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_ONE  = 2'b00,
    CS_MFC  = 2'b01,
    CS_COND = 2'b10,
    CS_ZERO = 2'b11
  } cond_sel_e;

endpackage

// File: rtl/microseq_next_addr.sv
// Combinational next-address selection for the microprogram sequencer.
// Ports:
//   ns_sel      : next-state select field of the current control word
//   t           : selected (and optionally inverted) condition
//   inc         : current index + 1 (wrapping)
//   cr_addr     : branch/call target field
//   decode_addr : entry address from the instruction decoder
//   ret         : micro-subroutine return address
//   next_addr   : address to load when the sequencer advances
//   stall       : WAIT whose condition is false; the caller holds the index
module microseq_next_addr
  import microseq_pkg::*;
#(
  parameter int ADDR_W     = MICROSEQ_ADDR_W,
  parameter int FETCH_ADDR = 1
) (
  input  logic [2:0]        ns_sel,
  input  logic              t,
  input  logic [ADDR_W-1:0] inc,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] decode_addr,
  input  logic [ADDR_W-1:0] ret,
  output logic [ADDR_W-1:0] next_addr,
  output logic              stall
);

  always_comb begin
    next_addr = inc;
    stall     = 1'b0;
    case (ns_sel)
      NS_INC:     next_addr = inc;
      NS_JUMP:    next_addr = cr_addr;
      NS_DECODE:  next_addr = decode_addr;
      NS_CBRANCH: next_addr = t ? cr_addr : inc;
      // next_addr is the advance target; holding is done by the index
      // register itself, which keeps the current value while stall is high.
      NS_WAIT: begin
        next_addr = inc;
        stall     = ~t;
      end
      NS_CALL:    next_addr = cr_addr;
      NS_RETURN:  next_addr = ret;
      NS_FETCH:   next_addr = ADDR_W'(FETCH_ADDR);
    endcase
  end

endmodule

// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: holds the micro-PC that addresses the microstore,
// a one-deep subroutine return register and an MFC-wait watchdog.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   ns_sel       : next-state select field of the current control word
//   cr_addr      : branch/call target field
//   inv          : inverts the selected condition
//   cond_sel     : 00 const 1, 01 mfc, 10 cond, 11 const 0
//   mfc, cond    : memory-function-complete and condition-tester inputs
//   decode_addr  : entry address from the instruction decoder
//   index        : registered micro-PC, drives the microstore address
//   stall        : combinational, current cycle is a WAIT with false condition
//   timeout      : registered one-cycle pulse when the watchdog traps
module microprogram_sequencer
  import microseq_pkg::*;
#(
  parameter int ADDR_W       = MICROSEQ_ADDR_W,
  parameter int RESET_ADDR   = 0,
  parameter int FETCH_ADDR   = 1,
  parameter int TRAP_ADDR    = 63,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ns_sel,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic              inv,
  input  logic [1:0]        cond_sel,
  input  logic              mfc,
  input  logic              cond,
  input  logic [ADDR_W-1:0] decode_addr,
  output logic [ADDR_W-1:0] index,
  output logic              stall,
  output logic              timeout
);

  localparam bit WD_EN = (WAIT_TIMEOUT > 0);
  // A disabled watchdog still gets a 1-bit counter so the widths stay legal.
  localparam int CNT_W = WD_EN ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(WAIT_TIMEOUT - 1) : '0;

  logic [ADDR_W-1:0] ret;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              sel_cond;
  logic              t;
  logic              fire;

  always_comb begin
    sel_cond = 1'b1;
    case (cond_sel)
      CS_ONE:  sel_cond = 1'b1;
      CS_MFC:  sel_cond = mfc;
      CS_COND: sel_cond = cond;
      CS_ZERO: sel_cond = 1'b0;
    endcase
  end

  assign t   = sel_cond ^ inv;
  assign inc = index + 1'b1;

  microseq_next_addr #(
    .ADDR_W     (ADDR_W),
    .FETCH_ADDR (FETCH_ADDR)
  ) u_next_addr (
    .ns_sel      (ns_sel),
    .t           (t),
    .inc         (inc),
    .cr_addr     (cr_addr),
    .decode_addr (decode_addr),
    .ret         (ret),
    .next_addr   (next_addr),
    .stall       (stall)
  );

  // Trap on the edge that would complete the WAIT_TIMEOUT-th stalled cycle;
  // a WAIT whose condition is true is not stalled and therefore never traps.
  assign fire = WD_EN && stall && (wait_cnt == CNT_LAST);

  // ---- state register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= ADDR_W'(RESET_ADDR);
      ret      <= ADDR_W'(FETCH_ADDR);
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= fire;
      if (fire) begin
        index    <= ADDR_W'(TRAP_ADDR);
        wait_cnt <= '0;
      end else begin
        index    <= stall ? index : next_addr;
        wait_cnt <= (WD_EN && stall) ? wait_cnt + 1'b1 : '0;
      end
      if (ns_sel == NS_CALL) begin
        ret <= inc;
      end
    end
  end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed bench for microprogram_sequencer (watchdog shortened to 4 cycles).
module tb_microprogram_sequencer;
  import microseq_pkg::*;

  typedef struct packed {
    logic [5:0] idx;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns_sel = 3'b000;
  logic [5:0] cr_addr = '0;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'b00;
  logic       mfc = 1'b0;
  logic       cond = 1'b0;
  logic [5:0] decode_addr = '0;
  logic [5:0] index;
  logic       stall;
  logic       timeout;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  microprogram_sequencer #(
    .ADDR_W       (6),
    .RESET_ADDR   (0),
    .FETCH_ADDR   (1),
    .TRAP_ADDR    (63),
    .WAIT_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ns_sel      (ns_sel),
    .cr_addr     (cr_addr),
    .inv         (inv),
    .cond_sel    (cond_sel),
    .mfc         (mfc),
    .cond        (cond),
    .decode_addr (decode_addr),
    .index       (index),
    .stall       (stall),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one control word; check stall before the edge, and index/timeout
  // after it against the expectation queued at drive time.
  task automatic step(input string tag, input logic [2:0] ns, input logic [5:0] cr,
                      input logic iv, input logic [1:0] cs, input logic m, input logic c,
                      input logic [5:0] dec, input logic exp_stall,
                      input logic [5:0] exp_idx, input logic exp_to);
    exp_t e;
    ns_sel = ns; cr_addr = cr; inv = iv; cond_sel = cs;
    mfc = m; cond = c; decode_addr = dec;
    sb_q.push_back('{idx: exp_idx, to: exp_to});
    #1;
    chk({tag, ".stall"}, {7'd0, stall}, {7'd0, exp_stall});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".index"}, {2'd0, index}, {2'd0, e.idx});
      chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e.to});
    end
  endtask

  // Pulse reset between edges and check it acts without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, ".index"}, {2'd0, index}, 8'd0);
    chk({tag, ".timeout"}, {7'd0, timeout}, 8'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.index", {2'd0, index}, 8'd0);
    chk("reset.timeout", {7'd0, timeout}, 8'd0);
    chk("reset.stall", {7'd0, stall}, 8'd0);
    reset = 1'b0;

    //   tag         ns          cr   inv cs   mfc cond dec  stall idx to
    step("inc0",     NS_INC,     0,   0, 2'b00, 0, 0, 0,  0,  1, 0);
    step("jmp23",    NS_JUMP,    23,  0, 2'b00, 0, 0, 0,  0, 23, 0);
    async_reset("midrst");
    step("inc_rel",  NS_INC,     0,   0, 2'b00, 0, 0, 0,  0,  1, 0);

    step("jmp63",    NS_JUMP,    63,  0, 2'b00, 0, 0, 0,  0, 63, 0);
    step("wrap",     NS_INC,     0,   0, 2'b00, 0, 0, 0,  0,  0, 0);
    step("jmp40",    NS_JUMP,    40,  0, 2'b00, 0, 0, 0,  0, 40, 0);
    step("decode",   NS_DECODE,  0,   0, 2'b00, 0, 0, 12, 0, 12, 0);
    step("cb_inv",   NS_CBRANCH, 30,  1, 2'b10, 0, 1, 0,  0, 13, 0);
    step("cb_take",  NS_CBRANCH, 30,  0, 2'b10, 0, 1, 0,  0, 30, 0);
    step("cb_zero",  NS_CBRANCH, 5,   0, 2'b11, 0, 0, 0,  0, 31, 0);
    step("cb_one",   NS_CBRANCH, 5,   0, 2'b00, 0, 0, 0,  0,  5, 0);

    step("wait1",    NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  5, 0);
    step("wait2",    NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  5, 0);
    step("wait3",    NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  5, 0);
    step("wait_go",  NS_WAIT,    0,   0, 2'b01, 1, 0, 0,  0,  6, 0);
    step("wait_inv", NS_WAIT,    0,   1, 2'b11, 0, 0, 0,  0,  7, 0);

    step("jmp9",     NS_JUMP,    9,   0, 2'b00, 0, 0, 0,  0,  9, 0);
    step("call50",   NS_CALL,    50,  0, 2'b00, 0, 0, 0,  0, 50, 0);
    step("call55",   NS_CALL,    55,  0, 2'b00, 0, 0, 0,  0, 55, 0);
    step("ret51",    NS_RETURN,  0,   0, 2'b00, 0, 0, 0,  0, 51, 0);
    step("ret51b",   NS_RETURN,  0,   0, 2'b00, 0, 0, 0,  0, 51, 0);
    step("fetch",    NS_FETCH,   0,   0, 2'b00, 0, 0, 0,  0,  1, 0);
    step("callself", NS_CALL,    1,   0, 2'b00, 0, 0, 0,  0,  1, 0);
    step("retself",  NS_RETURN,  0,   0, 2'b00, 0, 0, 0,  0,  2, 0);

    // Watchdog: fourth consecutive stalled cycle traps.
    step("jmp7",     NS_JUMP,    7,   0, 2'b00, 0, 0, 0,  0,  7, 0);
    step("wd1",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wd2",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wd3",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wd_trap",  NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1, 63, 1);
    step("wd_pulse", NS_INC,     0,   0, 2'b00, 0, 0, 0,  0,  0, 0);

    // Condition true on the cycle the watchdog would fire: advance instead.
    step("jmp7b",    NS_JUMP,    7,   0, 2'b00, 0, 0, 0,  0,  7, 0);
    step("wl1",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wl2",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wl3",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  7, 0);
    step("wl_go",    NS_WAIT,    0,   0, 2'b01, 1, 0, 0,  0,  8, 0);

    // Counter must restart after a completed WAIT.
    step("wc1",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  8, 0);
    step("wc2",      NS_WAIT,    0,   0, 2'b01, 0, 0, 0,  1,  8, 0);
    step("wc_go",    NS_WAIT,    0,   0, 2'b01, 1, 0, 0,  0,  9, 0);
    step("wc3",      NS_WAIT,    0,   0, 2'b10, 0, 0, 0,  1,  9, 0);
    step("wc4",      NS_WAIT,    0,   0, 2'b10, 0, 0, 0,  1,  9, 0);
    step("wc5",      NS_WAIT,    0,   0, 2'b10, 0, 0, 0,  1,  9, 0);
    step("wc_trap",  NS_WAIT,    0,   0, 2'b10, 0, 0, 0,  1, 63, 1);

    // Reset mid-CALL context, then RETURN falls back to FETCH_ADDR.
    step("call60",   NS_CALL,    60,  0, 2'b00, 0, 0, 0,  0, 60, 0);
    async_reset("rst2");
    step("ret_rst",  NS_RETURN,  0,   0, 2'b00, 0, 0, 0,  0,  1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
